uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the nibble program-memory address width (capacity 2^ADDR_WIDTH nibbles).
REQ-002 Parameter UART_DATA_LENGTH, default 8, SHALL be the received byte width; only 8 is supported.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, SHALL be the frame start marker.
REQ-004 clk_i  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset_ni  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 data_i  in  8  SHALL carry the received byte, valid only while data_valid_strb_i=1.
REQ-007 data_valid_strb_i  in  1  SHALL be a one-cycle byte-valid strobe from the UART receiver.
REQ-008 mem_we_o  out  1  SHALL be a one-cycle program-memory write enable.
REQ-009 mem_addr_o  out  ADDR_WIDTH  SHALL be the write address.
REQ-010 mem_data_o  out  4  SHALL be the write nibble.
REQ-011 loading_o  out  1  SHALL be high while a frame is in progress.
REQ-012 load_done_o  out  1  SHALL pulse for one cycle on successful frame completion.
REQ-013 cpu_run_o  out  1  SHALL be a level that releases the CPU.
REQ-014 err_o  out  1  SHALL be a sticky frame-error flag.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, length L (data bytes), L data bytes, then a checksum byte only when CHECKSUM_EN is defined.
REQ-016 The FSM states SHALL be stIDLE, stLEN, stDATA, stWRHI, stCHK.
REQ-017 stIDLE: a strobe with data_i==SYNC_BYTE SHALL go to stLEN, clear err_o and cpu_run_o, and zero the address counter and checksum; all other bytes SHALL be ignored.
REQ-018 stLEN: L==0 or L>2^(ADDR_WIDTH-1) SHALL set err_o and return to stIDLE; otherwise L SHALL be latched and the FSM SHALL go to stDATA.
REQ-019 stDATA: on a strobe, data_i[3:0] SHALL be written at the current address in the same cycle (mem_we_o=1), and data_i[7:4] SHALL be held; the FSM SHALL then go to stWRHI.
REQ-020 stWRHI: the held high nibble SHALL be written at address+1 in exactly one cycle; the address SHALL advance by 2 and the remaining count SHALL decrement by 1.
REQ-021 After the last byte's high nibble is written, the FSM SHALL go to stCHK when CHECKSUM_EN is defined; otherwise it SHALL complete (REQ-023).
REQ-022 A strobe arriving while in stWRHI SHALL be dropped and SHALL set err_o; the frame SHALL continue.
REQ-023 On completion, load_done_o SHALL pulse the next cycle, cpu_run_o SHALL go high, and the FSM SHALL return to stIDLE.
REQ-024 The address counter SHALL wrap modulo 2^ADDR_WIDTH; the length check in REQ-018 guarantees no wrap within a valid frame.
REQ-025 cpu_run_o SHALL stay high until the next SYNC_BYTE; a frame that sets err_o SHALL leave cpu_run_o low.
REQ-026 loading_o SHALL be 1 in every state except stIDLE.
REQ-027 When mem_we_o=0, mem_addr_o and mem_data_o SHALL hold their last values.

Reset
REQ-028 While reset_ni=0, the block SHALL be in stIDLE with every output, counter, latched length and checksum at 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no further writes; after reset release, the block SHALL need a fresh SYNC_BYTE to start.

Configuration
REQ-030 Macro UART_PROG_LOADER_CHECKSUM_EN defined: the XOR of all data bytes SHALL be accumulated, and in stCHK the next byte SHALL be compared with it.
  - Match: complete per REQ-023.
  - Mismatch: set err_o, return to stIDLE, no load_done_o, cpu_run_o stays low.
REQ-031 Macro undefined: no checksum logic SHALL exist, stCHK SHALL be unreachable, and the frame SHALL end after the last data byte.

Verification
REQ-032 A5,02,21,43 (+chk 62 if enabled) -> writes (0,1),(1,2),(2,3),(3,4); load_done_o pulses once; cpu_run_o=1; err_o=0.
REQ-033 A5,00 -> err_o=1, no writes, back in stIDLE; a following A5,01,F0 (+F0) -> err_o clears, writes (0,0),(1,F), then done.
REQ-034 A5,11 with ADDR_WIDTH=5 -> err_o=1, no writes; A5,10 followed by 16 bytes -> 32 writes at addresses 0..31, then done.
REQ-035 Strobe injected the cycle after a data-byte strobe -> byte dropped, err_o=1, cpu_run_o stays 0 at frame end.
REQ-036 reset_ni pulsed low after 1 of 2 data bytes -> outputs 0 at once; a later stray byte 21 -> no writes until A5 is received.
REQ-037 With CHECKSUM_EN: A5,01,3C,00 -> err_o=1, no load_done_o, cpu_run_o=0; the same frame with checksum 3C -> done.

Source files
------------

// File: rtl/uart_prog_loader.sv
// UART program loader: parses SYNC/length/data frames from a byte stream and writes nibbles to program memory.
// Optional checksum byte at frame end enabled by defining UART_PROG_LOADER_CHECKSUM_EN.
//
// state  | meaning
// stIDLE | waiting for SYNC_BYTE; CPU may be running
// stLEN  | waiting for length byte
// stDATA | waiting for a data byte; low nibble written on arrival
// stWRHI | writing held high nibble at address+1
// stCHK  | waiting for checksum byte (checksum build only)
module uart_prog_loader #(
  parameter int         ADDR_WIDTH       = 5,
  parameter int         UART_DATA_LENGTH = 8,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
  input  logic                        clk_i,
  input  logic                        reset_ni,
  input  logic [UART_DATA_LENGTH-1:0] data_i,
  input  logic                        data_valid_strb_i,
  output logic                        mem_we_o,
  output logic [ADDR_WIDTH-1:0]       mem_addr_o,
  output logic [3:0]                  mem_data_o,
  output logic                        loading_o,
  output logic                        load_done_o,
  output logic                        cpu_run_o,
  output logic                        err_o
);

  typedef enum logic [2:0] {stIDLE, stLEN, stDATA, stWRHI, stCHK} state_t;

  // Longest frame that fits: two nibbles per byte must not wrap the address space.
  localparam logic [8:0] MAX_LEN = 9'(2 ** (ADDR_WIDTH - 1));

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [3:0]            hi_q, hi_d;
  logic                  done_q, done_d;
  logic                  run_q, run_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] hold_addr_q;
  logic [3:0]            hold_data_q;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
  logic [7:0]            chk_q, chk_d;
`endif

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [3:0]            wr_data;
  logic [7:0]            rx_byte;
  logic                  strb;

  assign rx_byte = data_i[7:0];
  assign strb    = data_valid_strb_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= stIDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      hi_q        <= '0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
      err_q       <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      done_q  <= done_d;
      run_q   <= run_d;
      err_q   <= err_d;
      if (wr_en) begin
        hold_addr_q <= wr_addr;
        hold_data_q <= wr_data;
      end
`ifdef UART_PROG_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    done_d  = 1'b0;
    run_d   = run_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_addr = addr_q;
    wr_data = rx_byte[3:0];
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    case (state_q)
      stIDLE: begin
        if (strb && rx_byte == SYNC_BYTE) begin
          state_d = stLEN;
          err_d   = 1'b0;
          run_d   = 1'b0;
          addr_d  = '0;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end

      stLEN: begin
        if (strb) begin
          if (rx_byte == 8'd0 || {1'b0, rx_byte} > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = stIDLE;
          end else begin
            rem_d   = ADDR_WIDTH'(rx_byte);
            state_d = stDATA;
          end
        end
      end

      stDATA: begin
        if (strb) begin
          wr_en   = 1'b1;
          hi_d    = rx_byte[7:4];
          state_d = stWRHI;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ rx_byte;
`endif
        end
      end

      stWRHI: begin
        // The write slot is owned by the high nibble; an arriving byte is lost.
        wr_en   = 1'b1;
        wr_addr = addr_q + ADDR_WIDTH'(1);
        wr_data = hi_q;
        addr_d  = addr_q + ADDR_WIDTH'(2);
        rem_d   = rem_q - ADDR_WIDTH'(1);
        if (strb) err_d = 1'b1;
        if (rem_q == ADDR_WIDTH'(1)) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
          state_d = stCHK;
`else
          state_d = stIDLE;
          done_d  = !(err_q || strb);
          run_d   = !(err_q || strb);
`endif
        end else begin
          state_d = stDATA;
        end
      end

`ifdef UART_PROG_LOADER_CHECKSUM_EN
      stCHK: begin
        if (strb) begin
          state_d = stIDLE;
          if (rx_byte == chk_q) begin
            done_d = !err_q;
            run_d  = !err_q;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
`endif

      default: state_d = stIDLE;
    endcase
  end

  assign mem_we_o    = wr_en;
  assign mem_addr_o  = wr_en ? wr_addr : hold_addr_q;
  assign mem_data_o  = wr_en ? wr_data : hold_data_q;
  assign loading_o   = (state_q != stIDLE);
  assign load_done_o = done_q;
  assign cpu_run_o   = run_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: directed vector table, corner sequences and random frames.
// Follows UART_PROG_LOADER_CHECKSUM_EN the same way as the design.
module tb_uart_prog_loader;

  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic [7:0]    data_i = 8'h00;
  logic          data_valid_strb_i = 1'b0;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [3:0]    mem_data_o;
  logic          loading_o;
  logic          load_done_o;
  logic          cpu_run_o;
  logic          err_o;

  uart_prog_loader #(.ADDR_WIDTH(AW), .UART_DATA_LENGTH(8), .SYNC_BYTE(8'hA5)) dut (
    .clk_i            (clk_i),
    .reset_ni         (reset_ni),
    .data_i           (data_i),
    .data_valid_strb_i(data_valid_strb_i),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_data_o       (mem_data_o),
    .loading_o        (loading_o),
    .load_done_o      (load_done_o),
    .cpu_run_o        (cpu_run_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          n;
    logic [63:0] b;
    int          nwr;
    logic [47:0] wr;
    int          done;
    bit          run;
    bit          err;
  } vec_t;

  vec_t        vecs[7];
  int          cmp_cnt = 0;
  int          err_cnt = 0;
  logic [11:0] obs_q[$];
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_we_cyc = -10;
  int          last_strb_cyc = -10;
  int          done_cyc = -10;
  int          dbl_pulse = 0;
  logic        prev_done = 1'b0;

  // Observer samples mid-cycle, away from the rising edge.
  always @(negedge clk_i) begin
    cyc++;
    if (reset_ni) begin
      if (mem_we_o) begin
        obs_q.push_back({3'b000, mem_addr_o, mem_data_o});
        last_we_cyc = cyc;
      end
      if (data_valid_strb_i) last_strb_cyc = cyc;
      if (load_done_o) begin
        done_cnt++;
        done_cyc = cyc;
        if (prev_done) dbl_pulse++;
      end
    end
    prev_done = load_done_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    cmp_cnt++;
    if (act != exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(posedge clk_i);
    #1;
    data_i = b;
    data_valid_strb_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_valid_strb_i = 1'b0;
    data_i = 8'($urandom);
    tick(gap);
  endtask

  task automatic send_q(input logic [7:0] s[$], input bit rnd_gap);
    foreach (s[i]) send_byte(s[i], rnd_gap ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic check_frame(input string nm, input logic [11:0] e[$], input int done_before,
                             input int exp_done, input bit exp_run, input bit exp_err);
    int n;
    tick(4);
    chk({nm, " nwr"}, obs_q.size(), e.size());
    n = (obs_q.size() < e.size()) ? obs_q.size() : e.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s wr%0d", nm, k), obs_q[k], e[k]);
    if (exp_done >= 0) chk({nm, " done"}, done_cnt - done_before, exp_done);
    chk({nm, " run"}, cpu_run_o, exp_run);
    chk({nm, " err"}, err_o, exp_err);
    chk({nm, " loading"}, loading_o, 0);
  endtask

  // Builds a frame from its parts and predicts the outcome from the frame rules alone.
  task automatic run_frame(input string nm, input int len, input bit good_chk, input int n_stray);
    logic [7:0]  s[$];
    logic [11:0] e[$];
    logic [7:0]  x, d, b;
    bit          valid, ok;
    int          db;
    x = 8'h00;
    repeat (n_stray) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      s.push_back(b);
    end
    s.push_back(8'hA5);
    s.push_back(8'(len));
    valid = (len >= 1) && (len <= 16);
    if (valid) begin
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        s.push_back(d);
        x ^= d;
        e.push_back({8'(2 * i), d[3:0]});
        e.push_back({8'(2 * i + 1), d[7:4]});
      end
    end
    ok = valid;
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    if (valid) begin
      s.push_back(good_chk ? x : (x ^ 8'($urandom_range(1, 255))));
      ok = good_chk;
    end
`endif
    obs_q.delete();
    db = done_cnt;
    send_q(s, 1'b1);
    check_frame(nm, e, db, ok ? 1 : 0, ok, !ok);
  endtask

  initial begin
    logic [11:0] e[$];
    logic [7:0]  s[$];
    int          db;

    // Reset state
    tick(3);
    chk("rst we", mem_we_o, 0);
    chk("rst addr", mem_addr_o, 0);
    chk("rst data", mem_data_o, 0);
    chk("rst loading", loading_o, 0);
    chk("rst done", load_done_o, 0);
    chk("rst run", cpu_run_o, 0);
    chk("rst err", err_o, 0);
    reset_ni = 1'b1;
    tick(2);

`ifdef UART_PROG_LOADER_CHECKSUM_EN
    vecs[0] = '{5, 64'hA5022143_62000000, 4, 48'h001_012_023_034, 1, 1'b1, 1'b0};
    vecs[2] = '{4, 64'hA501F0F0_00000000, 2, 48'h000_01F_000_000, 1, 1'b1, 1'b0};
    vecs[5] = '{4, 64'hA5013C00_00000000, 2, 48'h00C_013_000_000, 0, 1'b0, 1'b1};
    vecs[6] = '{4, 64'hA5013C3C_00000000, 2, 48'h00C_013_000_000, 1, 1'b1, 1'b0};
`else
    vecs[0] = '{4, 64'hA5022143_00000000, 4, 48'h001_012_023_034, 1, 1'b1, 1'b0};
    vecs[2] = '{3, 64'hA501F000_00000000, 2, 48'h000_01F_000_000, 1, 1'b1, 1'b0};
    vecs[5] = '{3, 64'hA5013C00_00000000, 2, 48'h00C_013_000_000, 1, 1'b1, 1'b0};
    vecs[6] = '{3, 64'hA5015A00_00000000, 2, 48'h00A_015_000_000, 1, 1'b1, 1'b0};
`endif
    vecs[1] = '{2, 64'hA5000000_00000000, 0, 48'h0, 0, 1'b0, 1'b1};
    vecs[3] = '{2, 64'hA5110000_00000000, 0, 48'h0, 0, 1'b0, 1'b1};
    vecs[4] = '{2, 64'h21330000_00000000, 0, 48'h0, 0, 1'b0, 1'b1};

    for (int i = 0; i < 7; i++) begin
      e.delete();
      for (int k = 0; k < vecs[i].nwr; k++) e.push_back(vecs[i].wr[47-12*k -: 12]);
      obs_q.delete();
      db = done_cnt;
      for (int k = 0; k < vecs[i].n; k++) send_byte(vecs[i].b[63-8*k -: 8], 0);
      check_frame($sformatf("vec%0d", i), e, db, vecs[i].done, vecs[i].run, vecs[i].err);
      if (vecs[i].done == 1) begin
`ifdef UART_PROG_LOADER_CHECKSUM_EN
        chk($sformatf("vec%0d done_lat", i), done_cyc - last_strb_cyc, 1);
`else
        chk($sformatf("vec%0d done_lat", i), done_cyc - last_we_cyc, 1);
`endif
      end
    end

    // Largest legal frame fills the whole memory
    run_frame("full16", 16, 1'b1, 0);

    // Byte arriving during the high-nibble write is dropped
    obs_q.delete();
    db = done_cnt;
    send_byte(8'hA5, 0);
    chk("inj loading", loading_o, 1);
    send_byte(8'h02, 0);
    @(posedge clk_i); #1;
    data_i = 8'h21; data_valid_strb_i = 1'b1;
    @(posedge clk_i); #1;
    data_i = 8'h77;
    @(posedge clk_i); #1;
    data_valid_strb_i = 1'b0;
    send_byte(8'h43, 0);
`ifdef UART_PROG_LOADER_CHECKSUM_EN
    send_byte(8'h62, 0);
`endif
    e.delete();
    e.push_back(12'h001); e.push_back(12'h012); e.push_back(12'h023); e.push_back(12'h034);
    check_frame("inject", e, db, -1, 1'b0, 1'b1);

    // Reset in the middle of a frame
    run_frame("pre_rst", 2, 1'b1, 0);
    obs_q.delete();
    s.delete();
    s.push_back(8'hA5); s.push_back(8'h02); s.push_back(8'h21);
    send_q(s, 1'b0);
    tick(1);
    reset_ni = 1'b0;
    #1;
    chk("mid_rst we", mem_we_o, 0);
    chk("mid_rst addr", mem_addr_o, 0);
    chk("mid_rst data", mem_data_o, 0);
    chk("mid_rst loading", loading_o, 0);
    chk("mid_rst run", cpu_run_o, 0);
    chk("mid_rst err", err_o, 0);
    chk("mid_rst done", load_done_o, 0);
    tick(2);
    reset_ni = 1'b1;
    tick(2);
    chk("mid_rst nwr", obs_q.size(), 2);
    send_byte(8'h21, 0);
    send_byte(8'hF0, 0);
    tick(3);
    chk("stray nwr", obs_q.size(), 2);
    chk("stray loading", loading_o, 0);
    run_frame("post_rst", 1, 1'b1, 0);

    // Random frames
    for (int i = 0; i < 30; i++) begin
      int len;
      len = ($urandom_range(0, 3) != 0) ? int'($urandom_range(1, 16)) : int'($urandom_range(0, 40));
      run_frame($sformatf("rnd%0d", i), len, $urandom_range(0, 4) != 0, int'($urandom_range(0, 2)));
    end

    chk("done pulse width", dbl_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
